store_sched: RTL

Store scheduler between the multicycle control unit and data memory. It accepts store requests (word, half or byte), checks alignment and buffers them in a small in-order write queue. It issues each buffered store to memory with the lane code and byte enables the store-data formatter needs. It also flags load-after-store address hazards so the control unit can stall loads until the matching store has drained.

---
 rtl/store_sched_pkg.sv | 85 ++++++++
 rtl/store_sched_queue.sv | 78 +++++++
 rtl/store_sched.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/store_sched_pkg.sv
// Shared types and constants for the store scheduler: request opcodes,
// formatter lane codes, queue entry layout and the alignment/lane decode.
package store_sched_pkg;

    // Store request opcodes as presented by the control unit
    typedef enum logic [1:0] {
        ST_W   = 2'b00,
        ST_H   = 2'b01,
        ST_B   = 2'b10,
        ST_RSV = 2'b11
    } st_op_e;

    // Lane codes consumed by the store-data formatter
    localparam logic [3:0] S_SWORD = 4'b0001;
    localparam logic [3:0] S_SHL   = 4'b0010;
    localparam logic [3:0] S_SHU   = 4'b0011;
    localparam logic [3:0] S_SBL   = 4'b0100;
    localparam logic [3:0] S_SBM   = 4'b0101;
    localparam logic [3:0] S_SBH   = 4'b0110;
    localparam logic [3:0] S_SBU   = 4'b0111;

    // Issue FSM states
    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } sched_state_e;

    // One buffered store
    typedef struct packed {
        logic [29:0] waddr;
        logic [3:0]  s_type;
        logic [3:0]  be;
        logic [31:0] data;
    } sq_entry_t;

    // Result of the alignment check and lane decode
    typedef struct packed {
        logic       fault;
        logic [3:0] s_type;
        logic [3:0] be;
    } lane_t;

    // Alignment check plus lane/byte-enable selection for a store
    function automatic lane_t decode_lane(input st_op_e op, input logic [1:0] lo);
        lane_t l;
        l.fault  = 1'b0;
        l.s_type = 4'b0000;
        l.be     = 4'b0000;
        case (op)
            ST_W: begin
                if (lo == 2'b00) begin
                    l.s_type = S_SWORD;
                    l.be     = 4'b1111;
                end else begin
                    l.fault = 1'b1;
                end
            end
            ST_H: begin
                if (lo[0]) begin
                    l.fault = 1'b1;
                end else if (lo[1]) begin
                    l.s_type = S_SHU;
                    l.be     = 4'b1100;
                end else begin
                    l.s_type = S_SHL;
                    l.be     = 4'b0011;
                end
            end
            ST_B: begin
                case (lo)
                    2'b00:   begin l.s_type = S_SBL; l.be = 4'b0001; end
                    2'b01:   begin l.s_type = S_SBM; l.be = 4'b0010; end
                    2'b10:   begin l.s_type = S_SBH; l.be = 4'b0100; end
                    2'b11:   begin l.s_type = S_SBU; l.be = 4'b1000; end
                    default: begin l.fault = 1'b1; end
                endcase
            end
            default: begin
                l.fault = 1'b1;
            end
        endcase
        return l;
    endfunction

endpackage

// File: rtl/store_sched_queue.sv
// In-order circular write queue with per-entry word-address compare used to
// flag load-after-store hazards.
module store_queue
    import store_sched_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         push,
    input  sq_entry_t                    push_entry,
    input  logic                         pop,
    output sq_entry_t                    head,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         full,
    input  logic [29:0]                  ld_waddr,
    output logic                         ld_hazard
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [DEPTH-1:0] valid_r;
    sq_entry_t        entry_r [DEPTH];

    assign count = count_r;
    assign full  = (count_r == CW'(DEPTH));
    assign head  = entry_r[rd_ptr_r];

    // Pointer, count and valid-bit bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            valid_r  <= {DEPTH{1'b0}};
        end else begin
            if (pop) begin
                rd_ptr_r          <= rd_ptr_r + PW'(1);
                valid_r[rd_ptr_r] <= 1'b0;
            end
            if (push) begin
                wr_ptr_r          <= wr_ptr_r + PW'(1);
                valid_r[wr_ptr_r] <= 1'b1;
            end
            if (push && !pop) begin
                count_r <= count_r + CW'(1);
            end else if (pop && !push) begin
                count_r <= count_r - CW'(1);
            end else begin
                count_r <= count_r;
            end
        end
    end

    // Entry storage; contents are qualified by valid_r so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            entry_r[wr_ptr_r] <= push_entry;
        end
    end

    // Hazard when any valid entry, including the head in flight, hits the load word
    always_comb begin
        ld_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_r[i] && (entry_r[i].waddr == ld_waddr)) begin
                ld_hazard = 1'b1;
            end else begin
                ld_hazard = ld_hazard;
            end
        end
    end

endmodule

// File: rtl/store_sched.sv
// Store scheduler: decodes and alignment-checks store requests, buffers them
// in order, issues them to data memory and flags load-after-store hazards.
module store_sched
    import store_sched_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    output logic        exc_valid,
    output logic [31:0] exc_addr,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_s_type,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_data,
    input  logic        mem_ack,
    input  logic [31:0] ld_addr,
    output logic        ld_hazard,
    output logic        empty
);

    localparam int CW = $clog2(DEPTH) + 1;

    lane_t          lane_s;
    sq_entry_t      push_entry_s;
    sq_entry_t      head_s;
    logic           accept_s;
    logic           push_s;
    logic           exc_s;
    logic           pop_s;
    logic           full_s;
    logic [CW-1:0]  count_s;
    sched_state_e   state_r;
    sched_state_e   state_n;
    logic           exc_valid_r;
    logic [31:0]    exc_addr_r;
    logic           empty_r;
    logic           unused_ld_lo_s;

    // Byte offset of the load is irrelevant to a word-granular hazard check
    assign unused_ld_lo_s = ^ld_addr[1:0];

    // No bypass: a full queue refuses even while the head is being acknowledged
    assign req_ready = !full_s && reset_n;
    assign exc_valid = exc_valid_r;
    assign exc_addr  = exc_addr_r;
    assign empty     = empty_r;

    // Request decode: alignment check, lane selection and handshake split
    always_comb begin
        lane_s       = decode_lane(st_op_e'(req_op), req_addr[1:0]);
        accept_s     = req_valid && req_ready;
        push_s       = accept_s && !lane_s.fault;
        exc_s        = accept_s && lane_s.fault;
        pop_s        = (state_r == ISSUE) && mem_ack;
        push_entry_s = '{waddr:  req_addr[31:2],
                         s_type: lane_s.s_type,
                         be:     lane_s.be,
                         data:   req_data};
    end

    store_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (push_s),
        .push_entry (push_entry_s),
        .pop        (pop_s),
        .head       (head_s),
        .count      (count_s),
        .full       (full_s),
        .ld_waddr   (ld_addr[31:2]),
        .ld_hazard  (ld_hazard)
    );

    // Issue FSM state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state: leave ISSUE only when the last entry pops with nothing arriving
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE: begin
                if (push_s) begin
                    state_n = ISSUE;
                end else begin
                    state_n = IDLE;
                end
            end
            ISSUE: begin
                if (pop_s && !push_s && (count_s == CW'(1))) begin
                    state_n = IDLE;
                end else begin
                    state_n = ISSUE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Memory-side outputs follow the head entry only while issuing
    always_comb begin
        mem_we     = 1'b0;
        mem_addr   = 32'h0000_0000;
        mem_s_type = 4'b0000;
        mem_be     = 4'b0000;
        mem_data   = 32'h0000_0000;
        if (state_r == ISSUE) begin
            mem_we     = 1'b1;
            mem_addr   = {head_s.waddr, 2'b00};
            mem_s_type = head_s.s_type;
            mem_be     = head_s.be;
            mem_data   = head_s.data;
        end else begin
            mem_we     = 1'b0;
        end
    end

    // Address-error pulse and held faulting address
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            exc_valid_r <= 1'b0;
            exc_addr_r  <= 32'h0000_0000;
        end else begin
            exc_valid_r <= exc_s;
            if (exc_s) begin
                exc_addr_r <= req_addr;
            end else begin
                exc_addr_r <= exc_addr_r;
            end
        end
    end

    // Empty flag tracks the FSM: IDLE exactly when the queue holds nothing
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            empty_r <= 1'b1;
        end else begin
            empty_r <= (state_n == IDLE);
        end
    end

endmodule
